deck_dealer: RTL and testbench
==============================

# deck_dealer

Sequential consumer of a permuted deck: accepts a shuffled deck one card per beat over a valid/ready load stream, stores it, then deals cards back out in stored order over a valid/ready deal stream. It sits downstream of the shuffler in the card-game datapath and feeds game logic one card per request. It also checks deck integrity (duplicates, out-of-range codes, short decks) and supports re-dealing the same deck or flushing for a new one.

## Interface
- SIZE, 52: deck capacity in cards; legal card codes are 0..SIZE-1.
- CARD_W, 6: card code width; must satisfy 2**CARD_W >= SIZE.
- CNT_W, $clog2(SIZE+1): width of count/pointer fields.

- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  load beat present.
- load_ready  out  1  block accepts load beats.
- load_card  in  CARD_W  card code of current load beat.
- load_last  in  1  marks final card of a deck shorter than or equal to SIZE.
- out_valid  out  1  deal beat present.
- out_ready  in  1  consumer takes deal beat.
- out_card  out  CARD_W  card being dealt.
- out_last  out  1  high with the final card of the deck.
- restart  in  1  single-cycle pulse: re-deal stored deck from position 0.
- flush  in  1  single-cycle pulse: discard deck, return to LOAD.
- remaining  out  CNT_W  cards not yet dealt.
- empty  out  1  high in EMPTY state.
- err_dup  out  1  sticky: a card code loaded twice.
- err_range  out  1  sticky: a loaded code >= SIZE.
- err_short  out  1  sticky: load_last before SIZE cards.

## Operation
- States: LOAD (reset state), DEAL, EMPTY.
- LOAD: load_ready=1, out_valid=0. Accepted beat (load_valid & load_ready) writes mem[wr_ptr], wr_ptr+1, sets seen[card]. Deck count = wr_ptr+1 at the closing beat.
- LOAD exit: on accepted beat that is the SIZE-th, or carries load_last -> DEAL, rd_ptr=0, remaining=count. load_last on beat k<SIZE also sets err_short. Extra beats impossible (load_ready=0 outside LOAD).
- err_dup set if seen[card] already 1 on an accepted beat (codes < SIZE only). err_range set if card >= SIZE; card is still stored and dealt; seen not updated.
- DEAL: out_valid=1, out_card=mem[rd_ptr], out_last=(remaining==1). Handshake: rd_ptr+1, remaining-1; handshake with out_last -> EMPTY.
- EMPTY: empty=1, out_valid=0, remaining=0.
- restart (in DEAL or EMPTY): -> DEAL, rd_ptr=0, remaining=count; errors held. Ignored in LOAD.
- flush (any state): -> LOAD, wr_ptr=0, seen cleared, errors cleared; count cleared.
- Priority same cycle: flush > restart > handshake. A deal handshake coinciding with restart/flush is not consumed (rd_ptr not advanced by it).

## Timing
- Reset values: state LOAD, load_ready=1, out_valid=0, out_card=0, out_last=0, remaining=0, empty=0, all errors 0, wr_ptr=rd_ptr=0, seen all 0.
- load_ready, out_valid, out_last, empty decode from registered state only; no combinational path from any input to any output except out_card via registered rd_ptr.
- Closing load beat at edge N -> out_valid=1 from cycle N+1.
- Dealing with out_ready held high: one card per cycle, SIZE cards in SIZE cycles; empty=1 the cycle after the out_last handshake.
- out_valid stays high and out_card stable until handshake (no retraction).
- Error flags visible the cycle after the offending beat.
- rst mid-load or mid-deal: immediate return to reset values; stored mem contents irrelevant.

## Structure
- Package deck_pkg: state enum (LOAD, DEAL, EMPTY), default SIZE=52 and CARD_W=6 constants shared with the shuffler.
- Sub-module deck_store: SIZE x CARD_W register array, one write port, one asynchronous read port; control FSM, pointers, seen bitmap and error logic stay in deck_dealer.

## Test plan
- Load 0..51 in order, out_ready=1 -> out_card 0..51 on 52 consecutive cycles, out_last with card 51, empty=1 next cycle, no errors.
- Load permutation, out_ready toggled 1-0-1 -> out_card stable while out_ready=0, sequence matches load order, remaining decrements only on handshakes.
- Load 10 cards with load_last on 10th -> err_short=1, remaining=10, out_last on 10th dealt card.
- Load code 7 twice and code 60 once -> err_dup=1, err_range=1; flush -> both cleared, load_ready=1.
- Deal 20 cards, pulse restart with out_ready=1 -> next dealt card is mem[0], remaining=52.
- Assert rst after 30 dealt cards -> all outputs at reset values same cycle, new load accepted after release.

Source files
------------

// File: rtl/deck_pkg.sv
// Shared deck definitions for the card-game datapath.
// Provides the default deck geometry (also used by the shuffler) and the
// deal-controller state encoding.
package deck_pkg;

    localparam int unsigned DECK_SIZE   = 52;
    localparam int unsigned DECK_CARD_W = 6;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DEAL  = 2'd1,
        EMPTY = 2'd2
    } deal_state_e;

endpackage

// File: rtl/deck_store.sv
// Card storage for deck_dealer: SIZE x CARD_W register array, one
// synchronous write port and one asynchronous read port. Contents are not
// reset. Reads at addresses >= SIZE return zero.
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data (card code)
//   raddr_i  - read address
//   rdata_o  - read data (combinational from raddr_i)
module deck_store
    import deck_pkg::*;
#(
    parameter int unsigned SIZE   = DECK_SIZE,
    parameter int unsigned CARD_W = DECK_CARD_W,
    parameter int unsigned ADDR_W = $clog2(SIZE + 1)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [CARD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [CARD_W-1:0] rdata_o
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(SIZE);

    logic [CARD_W-1:0] mem_q [SIZE];

    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i < ADDR_LIMIT)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (raddr_i < ADDR_LIMIT) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/deck_dealer.sv
// Deck dealer: loads a shuffled deck one card per beat, then deals the
// cards back in stored order. Checks integrity while loading (duplicate
// codes, out-of-range codes, short decks) and supports restart (re-deal
// from position 0) and flush (discard deck, back to LOAD).
// Ports:
//   clk, rst                                  - clock, async active-high reset
//   load_valid/load_ready/load_card/load_last - load stream
//   out_valid/out_ready/out_card/out_last     - deal stream
//   restart, flush                            - single-cycle control pulses
//   remaining                                 - cards not yet dealt
//   empty                                     - deck fully dealt
//   err_dup, err_range, err_short             - sticky integrity flags
module deck_dealer
    import deck_pkg::*;
#(
    parameter int unsigned SIZE   = DECK_SIZE,
    parameter int unsigned CARD_W = DECK_CARD_W,
    parameter int unsigned CNT_W  = $clog2(SIZE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [CARD_W-1:0] load_card,
    input  logic              load_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CARD_W-1:0] out_card,
    output logic              out_last,
    input  logic              restart,
    input  logic              flush,
    output logic [CNT_W-1:0]  remaining,
    output logic              empty,
    output logic              err_dup,
    output logic              err_range,
    output logic              err_short
);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    deal_state_e       state_q, state_d;
    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SIZE-1:0]   seen_q, seen_d;
    logic              err_dup_q, err_dup_d;
    logic              err_range_q, err_range_d;
    logic              err_short_q, err_short_d;

    logic              load_beat;
    logic [SIZE-1:0]   card_oh;
    logic              card_in_range;
    logic              seen_hit;
    logic [CARD_W-1:0] rd_data;

    assign load_beat = load_valid && (state_q == LOAD);

    // One-hot of the incoming code; codes >= SIZE shift out entirely, so an
    // all-zero vector doubles as the out-of-range indication.
    assign card_oh       = {{(SIZE-1){1'b0}}, 1'b1} << load_card;
    assign card_in_range = |card_oh;
    assign seen_hit      = |(seen_q & card_oh);

    deck_store #(
        .SIZE   (SIZE),
        .CARD_W (CARD_W),
        .ADDR_W (CNT_W)
    ) u_store (
        .clk_i   (clk),
        .we_i    (load_beat),
        .waddr_i (wr_ptr_q),
        .wdata_i (load_card),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rem_d       = rem_q;
        count_d     = count_q;
        seen_d      = seen_q;
        err_dup_d   = err_dup_q;
        err_range_d = err_range_q;
        err_short_d = err_short_q;

        if (flush) begin
            state_d     = LOAD;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            rem_d       = '0;
            count_d     = '0;
            seen_d      = '0;
            err_dup_d   = 1'b0;
            err_range_d = 1'b0;
            err_short_d = 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (load_beat) begin
                        wr_ptr_d = wr_ptr_q + ONE;
                        if (card_in_range) begin
                            if (seen_hit) begin
                                err_dup_d = 1'b1;
                            end
                            seen_d = seen_q | card_oh;
                        end else begin
                            err_range_d = 1'b1;
                        end
                        if (load_last || (wr_ptr_q == LAST_SLOT)) begin
                            state_d  = DEAL;
                            rd_ptr_d = '0;
                            rem_d    = wr_ptr_q + ONE;
                            count_d  = wr_ptr_q + ONE;
                            if (load_last && (wr_ptr_q != LAST_SLOT)) begin
                                err_short_d = 1'b1;
                            end
                        end
                    end
                end
                DEAL, EMPTY: begin
                    // restart outranks a coinciding handshake, which is dropped
                    if (restart) begin
                        state_d  = DEAL;
                        rd_ptr_d = '0;
                        rem_d    = count_q;
                    end else if ((state_q == DEAL) && out_ready) begin
                        rd_ptr_d = rd_ptr_q + ONE;
                        rem_d    = rem_q - ONE;
                        if (rem_q == ONE) begin
                            state_d = EMPTY;
                        end
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rem_q       <= '0;
            count_q     <= '0;
            seen_q      <= '0;
            err_dup_q   <= 1'b0;
            err_range_q <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rem_q       <= rem_d;
            count_q     <= count_d;
            seen_q      <= seen_d;
            err_dup_q   <= err_dup_d;
            err_range_q <= err_range_d;
            err_short_q <= err_short_d;
        end
    end

    // Storage is not reset, so out_card is forced to zero outside DEAL.
    assign load_ready = (state_q == LOAD);
    assign out_valid  = (state_q == DEAL);
    assign out_last   = (state_q == DEAL) && (rem_q == ONE);
    assign out_card   = (state_q == DEAL) ? rd_data : '0;
    assign empty      = (state_q == EMPTY);
    assign remaining  = rem_q;
    assign err_dup    = err_dup_q;
    assign err_range  = err_range_q;
    assign err_short  = err_short_q;

endmodule

// File: tb/tb_deck_dealer.sv
module tb_deck_dealer;

    localparam int SIZE   = 52;
    localparam int CARD_W = 6;
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [CARD_W-1:0] load_card = '0;
    logic              load_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CARD_W-1:0] out_card;
    logic              out_last;
    logic              restart = 1'b0;
    logic              flush = 1'b0;
    logic [CNT_W-1:0]  remaining;
    logic              empty;
    logic              err_dup;
    logic              err_range;
    logic              err_short;

    int n_checks = 0;
    int n_fail   = 0;
    int deck [SIZE];

    always #5 clk = ~clk;

    deck_dealer #(
        .SIZE   (SIZE),
        .CARD_W (CARD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_card  (load_card),
        .load_last  (load_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_card   (out_card),
        .out_last   (out_last),
        .restart    (restart),
        .flush      (flush),
        .remaining  (remaining),
        .empty      (empty),
        .err_dup    (err_dup),
        .err_range  (err_range),
        .err_short  (err_short)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic load_deck(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_card  = CARD_W'(deck[i]);
            load_last  = use_last && (i == n - 1);
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // flags: {load_ready, out_valid, out_last, empty, err_dup, err_range, err_short}
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({load_ready, out_valid, out_last, empty, err_dup, err_range, err_short} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 1000000",
                     {load_ready, out_valid, out_last, empty, err_dup, err_range, err_short});
        end
        n_checks++;
        if ({remaining, out_card} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_counts: remaining=%0d out_card=%0d want 0/0", remaining, out_card);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_in_order();
        for (int i = 0; i < SIZE; i++) deck[i] = i;
        load_deck(SIZE, 1'b0);
        n_checks++;
        if ({load_ready, out_valid, empty} !== 3'b010 || remaining !== 6'd52) begin
            n_fail++;
            $display("FAIL inorder_start: rdy/vld/empty=%b rem=%0d want 010 rem=52",
                     {load_ready, out_valid, empty}, remaining);
        end
        out_ready = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
            n_checks++;
            if ({out_valid, out_last, out_card} !== {1'b1, (i == SIZE - 1), 6'(i)} ||
                remaining !== 6'(SIZE - i)) begin
                n_fail++;
                $display("FAIL inorder_deal[%0d]: vld=%b last=%b card=%0d rem=%0d want 1/%0d/%0d/%0d",
                         i, out_valid, out_last, out_card, remaining, (i == SIZE - 1), i, SIZE - i);
            end
            step();
        end
        out_ready = 1'b0;
        n_checks++;
        if ({empty, out_valid, out_last, err_dup, err_range, err_short} !== 6'b100000 || remaining !== 6'd0) begin
            n_fail++;
            $display("FAIL inorder_end: empty/vld/last/errs=%b rem=%0d want 100000 rem=0",
                     {empty, out_valid, out_last, err_dup, err_range, err_short}, remaining);
        end
    endtask

    task automatic test_stall();
        int idx = 0;
        int cyc = 0;
        pulse_flush();
        for (int i = 0; i < SIZE; i++) deck[i] = (i * 7) % SIZE;
        load_deck(SIZE, 1'b0);
        while (idx < SIZE && cyc < 300) begin
            n_checks++;
            if ({out_valid, out_card} !== {1'b1, 6'(deck[idx])} || remaining !== 6'(SIZE - idx)) begin
                n_fail++;
                $display("FAIL stall_deal cyc %0d: vld=%b card=%0d rem=%0d want 1/%0d/%0d",
                         cyc, out_valid, out_card, remaining, deck[idx], SIZE - idx);
            end
            out_ready = (cyc % 3 != 1);
            step();
            if (out_ready) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (idx != SIZE || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_end: dealt=%0d empty=%b want %0d/1", idx, empty, SIZE);
        end
    endtask

    task automatic test_short();
        pulse_flush();
        for (int i = 0; i < 10; i++) deck[i] = 20 + i;
        load_deck(10, 1'b1);
        n_checks++;
        if ({err_dup, err_range, err_short} !== 3'b001 || remaining !== 6'd10) begin
            n_fail++;
            $display("FAIL short_load: errs=%b rem=%0d want 001 rem=10",
                     {err_dup, err_range, err_short}, remaining);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({out_valid, out_last, out_card} !== {1'b1, (i == 9), 6'(20 + i)}) begin
                n_fail++;
                $display("FAIL short_deal[%0d]: vld=%b last=%b card=%0d want 1/%0d/%0d",
                         i, out_valid, out_last, out_card, (i == 9), 20 + i);
            end
            step();
        end
        out_ready = 1'b0;
        n_checks++;
        if (empty !== 1'b1 || remaining !== 6'd0) begin
            n_fail++;
            $display("FAIL short_end: empty=%b rem=%0d want 1/0", empty, remaining);
        end
    endtask

    task automatic test_errors();
        pulse_flush();
        deck[0] = 7; deck[1] = 3; deck[2] = 7; deck[3] = 60; deck[4] = 9;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_card  = CARD_W'(deck[i]);
            load_last  = (i == 4);
            step();
            if (i == 1 || i == 2 || i == 3) begin
                n_checks++;
                if ({err_dup, err_range} !== {(i >= 2), (i >= 3)}) begin
                    n_fail++;
                    $display("FAIL err_flags beat %0d: dup=%b range=%b want %0d/%0d",
                             i, err_dup, err_range, (i >= 2), (i >= 3));
                end
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        n_checks++;
        if ({err_dup, err_range, err_short} !== 3'b111) begin
            n_fail++;
            $display("FAIL err_all: errs=%b want 111", {err_dup, err_range, err_short});
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_card !== 6'(deck[i])) begin
                n_fail++;
                $display("FAIL err_deal[%0d]: card=%0d want %0d", i, out_card, deck[i]);
            end
            step();
        end
        out_ready = 1'b0;
        pulse_flush();
        n_checks++;
        if ({load_ready, out_valid, empty, err_dup, err_range, err_short} !== 6'b100000 || remaining !== 6'd0) begin
            n_fail++;
            $display("FAIL err_flush: rdy/vld/empty/errs=%b rem=%0d want 100000 rem=0",
                     {load_ready, out_valid, empty, err_dup, err_range, err_short}, remaining);
        end
    endtask

    task automatic test_restart();
        for (int i = 0; i < SIZE; i++) deck[i] = (i * 5) % SIZE;
        load_deck(SIZE, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        n_checks++;
        if (out_card !== 6'(deck[20]) || remaining !== 6'd32) begin
            n_fail++;
            $display("FAIL restart_pre: card=%0d rem=%0d want %0d/32", out_card, remaining, deck[20]);
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        n_checks++;
        if ({out_valid, out_card} !== {1'b1, 6'(deck[0])} || remaining !== 6'd52) begin
            n_fail++;
            $display("FAIL restart_deal: vld=%b card=%0d rem=%0d want 1/%0d/52",
                     out_valid, out_card, remaining, deck[0]);
        end
        step();
        n_checks++;
        if (out_card !== 6'(deck[1]) || remaining !== 6'd51) begin
            n_fail++;
            $display("FAIL restart_next: card=%0d rem=%0d want %0d/51", out_card, remaining, deck[1]);
        end
        for (int i = 0; i < 51; i++) step();
        out_ready = 1'b0;
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_empty: empty=%b want 1", empty);
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        n_checks++;
        if ({out_valid, empty, out_card} !== {2'b10, 6'(deck[0])} || remaining !== 6'd52) begin
            n_fail++;
            $display("FAIL restart_from_empty: vld=%b empty=%b card=%0d rem=%0d want 1/0/%0d/52",
                     out_valid, empty, out_card, remaining, deck[0]);
        end
        flush   = 1'b1;
        restart = 1'b1;
        step();
        flush   = 1'b0;
        n_checks++;
        if ({load_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_over_restart: rdy/vld=%b want 10", {load_ready, out_valid});
        end
        step();
        restart = 1'b0;
        n_checks++;
        if ({load_ready, out_valid} !== 2'b10 || remaining !== 6'd0) begin
            n_fail++;
            $display("FAIL restart_in_load: rdy/vld=%b rem=%0d want 10 rem=0",
                     {load_ready, out_valid}, remaining);
        end
    endtask

    task automatic test_rst_mid_deal();
        for (int i = 0; i < SIZE; i++) deck[i] = SIZE - 1 - i;
        load_deck(SIZE, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) step();
        n_checks++;
        if (out_card !== 6'd21 || remaining !== 6'd22) begin
            n_fail++;
            $display("FAIL rst_pre: card=%0d rem=%0d want 21/22", out_card, remaining);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({load_ready, out_valid, out_last, empty, err_dup, err_range, err_short} !== 7'b1000000 ||
            {remaining, out_card} !== 12'd0) begin
            n_fail++;
            $display("FAIL rst_async: flags=%b rem=%0d card=%0d want 1000000/0/0",
                     {load_ready, out_valid, out_last, empty, err_dup, err_range, err_short},
                     remaining, out_card);
        end
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        deck[0] = 4; deck[1] = 8; deck[2] = 15;
        load_deck(3, 1'b1);
        n_checks++;
        if ({out_valid, err_short, out_card} !== {2'b11, 6'd4} || remaining !== 6'd3) begin
            n_fail++;
            $display("FAIL rst_reload: vld=%b short=%b card=%0d rem=%0d want 1/1/4/3",
                     out_valid, err_short, out_card, remaining);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_stall();
        test_short();
        test_errors();
        test_restart();
        test_rst_mid_deal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
